// File: rtl/lsu_sq.sv
// Store queue: buffers committed-order stores from LSU_ID and drains one ROB-retired
// store at a time into the data cache, then notifies the LQ of the retired address.
`ifndef SQ_DEPTH
`define SQ_DEPTH 8
`endif

package procyon_pkg;
    localparam int TAG_W  = 6;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef logic [TAG_W-1:0]  procyon_tag_t;
    typedef logic [ADDR_W-1:0] procyon_addr_t;
    typedef logic [DATA_W-1:0] procyon_data_t;
    typedef logic [2:0]        procyon_lsu_func_t;

    localparam procyon_lsu_func_t LSU_FUNC_SB = 3'd5;
    localparam procyon_lsu_func_t LSU_FUNC_SH = 3'd6;
    localparam procyon_lsu_func_t LSU_FUNC_SW = 3'd7;
endpackage

// state | meaning
// IDLE  | waiting for the ROB to retire a store held in the queue
// WRITE | latched slot's write presented to the data cache until acked
// DONE  | one-cycle retire notice to the LQ; latched slot freed at end
module lsu_sq
    import procyon_pkg::*;
#(
    parameter int SQ_DEPTH = `SQ_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_flush,
    output logic              o_full,
    input  procyon_tag_t      i_alloc_tag,
    input  procyon_addr_t     i_alloc_addr,
    input  procyon_data_t     i_alloc_data,
    input  procyon_lsu_func_t i_alloc_lsu_func,
    input  logic              i_alloc_en,
    input  procyon_tag_t      i_rob_retire_tag,
    input  logic              i_rob_retire_en,
    output logic              o_rob_retire_stall,
    output procyon_addr_t     o_dc_wr_addr,
    output procyon_data_t     o_dc_wr_data,
    output procyon_lsu_func_t o_dc_wr_lsu_func,
    output logic              o_dc_wr_en,
    input  logic              i_dc_wr_ack,
    output procyon_addr_t     o_sq_retire_addr,
    output procyon_lsu_func_t o_sq_retire_lsu_func,
    output logic              o_sq_retire_en
);

    localparam int IDX_W = $clog2(SQ_DEPTH);
    localparam int CNT_W = $clog2(SQ_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       slot_q, slot_d;
    logic [SQ_DEPTH-1:0]    valid_q, valid_d;

    procyon_tag_t           tag_q  [SQ_DEPTH];
    procyon_addr_t          addr_q [SQ_DEPTH];
    procyon_data_t          data_q [SQ_DEPTH];
    procyon_lsu_func_t      func_q [SQ_DEPTH];

    logic                   alloc_ok;
    logic [IDX_W-1:0]       alloc_idx;
    logic [IDX_W-1:0]       match_idx;
    logic [CNT_W-1:0]       match_cnt;

    assign o_full   = &valid_q;
    assign alloc_ok = i_alloc_en && !o_full && !i_flush;

    always_comb begin
        alloc_idx = '0;
        for (int i = SQ_DEPTH - 1; i >= 0; i--) begin
            if (!valid_q[i]) alloc_idx = IDX_W'(i);
        end
    end

    // A retire is only honoured when the tag identifies a single live slot.
    always_comb begin
        match_cnt = '0;
        match_idx = '0;
        for (int i = 0; i < SQ_DEPTH; i++) begin
            if (valid_q[i] && (tag_q[i] == i_rob_retire_tag)) begin
                match_cnt = match_cnt + CNT_W'(1);
                match_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        case (state_q)
            IDLE: begin
                if (i_rob_retire_en && (match_cnt == CNT_W'(1))) begin
                    state_d = WRITE;
                    slot_d  = match_idx;
                end
            end
            WRITE:   if (i_dc_wr_ack) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The latched slot survives a flush: the ROB has already committed it.
    always_comb begin
        valid_d = valid_q;
        if (i_flush) begin
            for (int i = 0; i < SQ_DEPTH; i++) begin
                if (!((state_q != IDLE) && (slot_q == IDX_W'(i)))) valid_d[i] = 1'b0;
            end
        end else if (alloc_ok) begin
            valid_d[alloc_idx] = 1'b1;
        end
        if (state_q == DONE) valid_d[slot_q] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            slot_q  <= '0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && alloc_ok) begin
            tag_q[alloc_idx]  <= i_alloc_tag;
            addr_q[alloc_idx] <= i_alloc_addr;
            data_q[alloc_idx] <= i_alloc_data;
            func_q[alloc_idx] <= i_alloc_lsu_func;
        end
    end

    assign o_rob_retire_stall   = (state_q != IDLE);
    assign o_dc_wr_en           = (state_q == WRITE);
    assign o_sq_retire_en       = (state_q == DONE);
    assign o_dc_wr_addr         = addr_q[slot_q];
    assign o_dc_wr_data         = data_q[slot_q];
    assign o_dc_wr_lsu_func     = func_q[slot_q];
    assign o_sq_retire_addr     = addr_q[slot_q];
    assign o_sq_retire_lsu_func = func_q[slot_q];

endmodule

// File: tb/tb_lsu_sq.sv
// Store queue bench: directed scenarios with literal expectations, then random traffic,
// all cross-checked every cycle against a slot-table model of the queue.
module tb_lsu_sq;
    import procyon_pkg::*;

    localparam int DEPTH = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_flush;
    logic              o_full;
    procyon_tag_t      i_alloc_tag;
    procyon_addr_t     i_alloc_addr;
    procyon_data_t     i_alloc_data;
    procyon_lsu_func_t i_alloc_lsu_func;
    logic              i_alloc_en;
    procyon_tag_t      i_rob_retire_tag;
    logic              i_rob_retire_en;
    logic              o_rob_retire_stall;
    procyon_addr_t     o_dc_wr_addr;
    procyon_data_t     o_dc_wr_data;
    procyon_lsu_func_t o_dc_wr_lsu_func;
    logic              o_dc_wr_en;
    logic              i_dc_wr_ack;
    procyon_addr_t     o_sq_retire_addr;
    procyon_lsu_func_t o_sq_retire_lsu_func;
    logic              o_sq_retire_en;

    lsu_sq #(.SQ_DEPTH(DEPTH)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .i_flush              (i_flush),
        .o_full               (o_full),
        .i_alloc_tag          (i_alloc_tag),
        .i_alloc_addr         (i_alloc_addr),
        .i_alloc_data         (i_alloc_data),
        .i_alloc_lsu_func     (i_alloc_lsu_func),
        .i_alloc_en           (i_alloc_en),
        .i_rob_retire_tag     (i_rob_retire_tag),
        .i_rob_retire_en      (i_rob_retire_en),
        .o_rob_retire_stall   (o_rob_retire_stall),
        .o_dc_wr_addr         (o_dc_wr_addr),
        .o_dc_wr_data         (o_dc_wr_data),
        .o_dc_wr_lsu_func     (o_dc_wr_lsu_func),
        .o_dc_wr_en           (o_dc_wr_en),
        .i_dc_wr_ack          (i_dc_wr_ack),
        .o_sq_retire_addr     (o_sq_retire_addr),
        .o_sq_retire_lsu_func (o_sq_retire_lsu_func),
        .o_sq_retire_en       (o_sq_retire_en)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endfunction

    // Model: a table of slots plus "a store is in flight" / "its write was acked".
    bit                m_v    [DEPTH];
    procyon_tag_t      m_tag  [DEPTH];
    procyon_addr_t     m_addr [DEPTH];
    procyon_data_t     m_data [DEPTH];
    procyon_lsu_func_t m_func [DEPTH];
    bit                m_busy, m_acked;
    int                m_idx;

    int mdl_free_slot, mdl_hits, mdl_hit, mdl_idx_pre;
    bit mdl_freeing, mdl_busy_pre;

    always @(posedge clk) begin
        if (rst) begin
            foreach (m_v[i]) m_v[i] = 1'b0;
            m_busy  = 1'b0;
            m_acked = 1'b0;
            m_idx   = 0;
        end else begin
            mdl_busy_pre  = m_busy;
            mdl_idx_pre   = m_idx;
            mdl_freeing   = m_busy && m_acked;
            mdl_free_slot = -1;
            for (int i = DEPTH - 1; i >= 0; i--) if (!m_v[i]) mdl_free_slot = i;

            if (!m_busy) begin
                if (i_rob_retire_en) begin
                    mdl_hits = 0;
                    mdl_hit  = 0;
                    for (int i = 0; i < DEPTH; i++) begin
                        if (m_v[i] && m_tag[i] == i_rob_retire_tag) begin
                            mdl_hits++;
                            mdl_hit = i;
                        end
                    end
                    if (mdl_hits == 1) begin
                        m_busy  = 1'b1;
                        m_acked = 1'b0;
                        m_idx   = mdl_hit;
                    end
                end
            end else if (!m_acked) begin
                if (i_dc_wr_ack) m_acked = 1'b1;
            end else begin
                m_busy  = 1'b0;
                m_acked = 1'b0;
            end

            if (i_flush) begin
                for (int i = 0; i < DEPTH; i++)
                    if (!(mdl_busy_pre && i == mdl_idx_pre)) m_v[i] = 1'b0;
            end else if (i_alloc_en && mdl_free_slot >= 0) begin
                m_v[mdl_free_slot]    = 1'b1;
                m_tag[mdl_free_slot]  = i_alloc_tag;
                m_addr[mdl_free_slot] = i_alloc_addr;
                m_data[mdl_free_slot] = i_alloc_data;
                m_func[mdl_free_slot] = i_alloc_lsu_func;
            end
            if (mdl_freeing) m_v[mdl_idx_pre] = 1'b0;
        end
    end

    bit all_v;
    always @(negedge clk) begin
        if (chk_en) begin
            all_v = 1'b1;
            foreach (m_v[i]) if (!m_v[i]) all_v = 1'b0;
            chk("full", o_full, all_v);
            chk("stall", o_rob_retire_stall, m_busy);
            chk("dc_wr_en", o_dc_wr_en, m_busy && !m_acked);
            chk("sq_retire_en", o_sq_retire_en, m_busy && m_acked);
            if (m_busy && !m_acked) begin
                chk("dc_wr_addr", o_dc_wr_addr, m_addr[m_idx]);
                chk("dc_wr_data", o_dc_wr_data, m_data[m_idx]);
                chk("dc_wr_func", o_dc_wr_lsu_func, m_func[m_idx]);
            end
            if (m_busy && m_acked) begin
                chk("sq_ret_addr", o_sq_retire_addr, m_addr[m_idx]);
                chk("sq_ret_func", o_sq_retire_lsu_func, m_func[m_idx]);
            end
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        rst = 1'b0; i_flush = 1'b0; i_alloc_en = 1'b0; i_rob_retire_en = 1'b0; i_dc_wr_ack = 1'b0;
        i_alloc_tag = '0; i_alloc_addr = '0; i_alloc_data = '0; i_alloc_lsu_func = LSU_FUNC_SW;
        i_rob_retire_tag = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    task automatic alloc(input int tag, input logic [31:0] addr, input logic [31:0] data,
                         input procyon_lsu_func_t func);
        i_alloc_en = 1'b1; i_alloc_tag = procyon_tag_t'(tag);
        i_alloc_addr = addr; i_alloc_data = data; i_alloc_lsu_func = func;
        cyc();
        i_alloc_en = 1'b0;
    endtask

    task automatic retire(input int tag);
        i_rob_retire_en = 1'b1; i_rob_retire_tag = procyon_tag_t'(tag);
        cyc();
        i_rob_retire_en = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        do_reset();
        chk_en = 1'b1;
        chk("rst_full", o_full, 0);
        chk("rst_stall", o_rob_retire_stall, 0);
        chk("rst_wr_en", o_dc_wr_en, 0);
        chk("rst_ret_en", o_sq_retire_en, 0);

        // basic retirement with a two-cycle ack delay
        alloc(3, 32'h100, 32'hDEADBEEF, LSU_FUNC_SW);
        retire(3);
        chk("t1_wr_en_c1", o_dc_wr_en, 1);
        chk("t1_wr_addr", o_dc_wr_addr, 32'h100);
        chk("t1_wr_data", o_dc_wr_data, 32'hDEADBEEF);
        cyc();
        chk("t1_wr_en_c2", o_dc_wr_en, 1);
        cyc();
        chk("t1_wr_en_c3", o_dc_wr_en, 1);
        chk("t1_wr_data_c3", o_dc_wr_data, 32'hDEADBEEF);
        i_dc_wr_ack = 1'b1;
        cyc();
        i_dc_wr_ack = 1'b0;
        chk("t1_wr_en_off", o_dc_wr_en, 0);
        chk("t1_ret_en", o_sq_retire_en, 1);
        chk("t1_ret_addr", o_sq_retire_addr, 32'h100);
        chk("t1_ret_func", o_sq_retire_lsu_func, LSU_FUNC_SW);
        cyc();
        chk("t1_ret_pulse", o_sq_retire_en, 0);
        chk("t1_idle", o_rob_retire_stall, 0);
        retire(3);
        chk("t1_slot_freed", o_rob_retire_stall, 0);

        // fill, overflow, free one, refill
        do_reset();
        for (int i = 0; i < DEPTH; i++) alloc(10 + i, 32'h200 + 32'(i * 4), 32'(i), LSU_FUNC_SW);
        chk("t2_full", o_full, 1);
        alloc(50, 32'h500, 32'h5, LSU_FUNC_SB);
        chk("t2_full_drop", o_full, 1);
        retire(12);
        chk("t2_wr_addr", o_dc_wr_addr, 32'h208);
        i_dc_wr_ack = 1'b1;
        cyc();
        i_dc_wr_ack = 1'b0;
        chk("t2_full_ack1", o_full, 1);
        cyc();
        chk("t2_full_ack2", o_full, 0);
        alloc(60, 32'h600, 32'h6, LSU_FUNC_SH);
        chk("t2_refull", o_full, 1);
        retire(50);
        chk("t2_dropped_absent", o_rob_retire_stall, 0);

        // retire of an unknown tag
        do_reset();
        alloc(4, 32'h40, 32'h4, LSU_FUNC_SW);
        retire(5);
        chk("t3_nomatch_stall", o_rob_retire_stall, 0);
        chk("t3_nomatch_wr", o_dc_wr_en, 0);

        // flush during WRITE
        do_reset();
        alloc(1, 32'h10, 32'h11, LSU_FUNC_SW);
        alloc(2, 32'h20, 32'h22, LSU_FUNC_SB);
        retire(1);
        chk("t4_wr_en", o_dc_wr_en, 1);
        i_flush = 1'b1;
        cyc();
        i_flush = 1'b0;
        chk("t4_wr_after_flush", o_dc_wr_en, 1);
        chk("t4_wr_addr", o_dc_wr_addr, 32'h10);
        i_dc_wr_ack = 1'b1;
        cyc();
        i_dc_wr_ack = 1'b0;
        chk("t4_ret_en", o_sq_retire_en, 1);
        chk("t4_ret_addr", o_sq_retire_addr, 32'h10);
        cyc();
        retire(2);
        chk("t4_tag2_flushed", o_rob_retire_stall, 0);

        // reset during WRITE
        do_reset();
        alloc(7, 32'h70, 32'h77, LSU_FUNC_SW);
        retire(7);
        chk("t5_wr_en", o_dc_wr_en, 1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("t5_wr_abandon", o_dc_wr_en, 0);
        chk("t5_full", o_full, 0);
        chk("t5_ret_en", o_sq_retire_en, 0);
        i_dc_wr_ack = 1'b1;
        repeat (3) begin
            cyc();
            chk("t5_no_ret", o_sq_retire_en, 0);
        end
        i_dc_wr_ack = 1'b0;

        // alloc and flush in the same cycle
        do_reset();
        i_flush = 1'b1;
        alloc(8, 32'h80, 32'h88, LSU_FUNC_SW);
        i_flush = 1'b0;
        retire(8);
        chk("t6_flush_beats_alloc", o_rob_retire_stall, 0);

        // alloc during DONE must not land in the slot being freed
        do_reset();
        alloc(1, 32'h10, 32'h1, LSU_FUNC_SW);
        alloc(2, 32'h20, 32'h2, LSU_FUNC_SW);
        alloc(3, 32'h30, 32'h3, LSU_FUNC_SW);
        retire(1);
        i_dc_wr_ack = 1'b1;
        cyc();
        i_dc_wr_ack = 1'b0;
        chk("t7_in_done", o_sq_retire_en, 1);
        alloc(9, 32'h90, 32'h9, LSU_FUNC_SW);
        for (int i = 0; i < DEPTH - 3; i++) alloc(20 + i, 32'h1000 + 32'(i), 32'(i), LSU_FUNC_SB);
        chk("t7_done_alloc_no_reuse", o_full, 1);
        retire(9);
        chk("t7_tag9_kept", o_dc_wr_addr, 32'h90);
        i_dc_wr_ack = 1'b1;
        cyc();
        i_dc_wr_ack = 1'b0;
        cyc();

        // random traffic
        do_reset();
        repeat (4000) begin
            rst              = ($urandom_range(0, 299) == 0);
            i_flush          = ($urandom_range(0, 39) == 0);
            i_alloc_en       = ($urandom_range(0, 1) == 1);
            i_alloc_tag      = procyon_tag_t'($urandom_range(0, 7));
            i_alloc_addr     = $urandom;
            i_alloc_data     = $urandom;
            i_alloc_lsu_func = procyon_lsu_func_t'($urandom_range(5, 7));
            i_rob_retire_en  = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 1) == 1)
                i_rob_retire_tag = m_tag[$urandom_range(0, DEPTH - 1)];
            else
                i_rob_retire_tag = procyon_tag_t'($urandom_range(0, 9));
            i_dc_wr_ack      = ($urandom_range(0, 2) == 0);
            cyc();
        end
        idle_inputs();
        cyc();
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
